bus_arbiter_rr: RTL

Round-robin arbiter and watchdog for the shared bus used by `ramDmaCi` instances and other bus masters. Each master raises its request line; the arbiter returns a one-cycle grant and tracks ownership from `beginTransaction` to `endTransaction`. It also aborts transactions that stall, by driving a bus error and end-of-transaction. One instance sits between all masters' `requestTransaction`/`transactionGranted` pairs and the shared bus control lines.

---
 rtl/bus_arbiter_rr.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
//
// Round-robin arbiter and watchdog for the shared bus. Masters raise their
// request line and receive a one-cycle grant pulse. The arbiter then tracks
// ownership from begin-of-transaction to end-of-transaction. A transaction
// that stalls is aborted by a one-cycle bus error plus end-of-transaction.
//
// Parameters
//   NUM_MASTERS     number of requesters (2..16)
//   BEGIN_WINDOW    cycles a granted master has to assert beginTransactionIn
//   TIMEOUT_CYCLES  idle bus cycles tolerated inside a transaction
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous, active-low; clears all state
//   request             per-master transaction request
//   grant               per-master grant, registered one-hot single-cycle pulse
//   beginTransactionIn  shared bus begin-of-transaction
//   endTransactionIn    shared bus end-of-transaction
//   dataValidIn         shared bus data-valid
//   busErrorIn          shared bus error
//   busErrorOut         arbiter-driven bus error (abort pulse)
//   endTransactionOut   arbiter-driven end-of-transaction (abort pulse)
//   busActive           high while a master owns the bus
//   busOwner            index of the most recently granted master
//   timeoutFlag         sticky abort indicator, cleared only by reset
module bus_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int BEGIN_WINDOW   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  output logic [NUM_MASTERS-1:0]         grant,
  input  logic                           beginTransactionIn,
  input  logic                           endTransactionIn,
  input  logic                           dataValidIn,
  input  logic                           busErrorIn,
  output logic                           busErrorOut,
  output logic                           endTransactionOut,
  output logic                           busActive,
  output logic [$clog2(NUM_MASTERS)-1:0] busOwner,
  output logic                           timeoutFlag
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int WW = $clog2(BEGIN_WINDOW) + 1;
  localparam int DW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BEGIN,
    BUSY,
    ABORT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] pointer;
  logic [PW-1:0] pick;
  logic          pick_valid;
  logic [WW-1:0] win_cnt;
  logic [DW-1:0] wd_cnt;
  logic          win_done;
  logic          wd_done;

  assign win_done = (win_cnt >= WW'(BEGIN_WINDOW - 1));
  assign wd_done  = (wd_cnt >= DW'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: scan offsets from the highest down so the last hit,
  // which wins, is the requester closest to the pointer (searching upward
  // with wrap-around).
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(pointer) + i;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (request[idx[PW-1:0]]) begin
        pick       = idx[PW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Inside a transaction, an end (even with a bus error)
  // always returns to IDLE. Any data-valid or error cycle counts as bus
  // activity and defers the watchdog abort.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state = WAIT_BEGIN;
        end
      end
      WAIT_BEGIN: begin
        if (beginTransactionIn && endTransactionIn) begin
          next_state = IDLE;
        end else if (beginTransactionIn) begin
          next_state = BUSY;
        end else if (win_done) begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (endTransactionIn) begin
          next_state = IDLE;
        end else if (!(dataValidIn || busErrorIn) && wd_done) begin
          next_state = ABORT;
        end
      end
      ABORT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant, ownership, pointer and counters. The grant is a single-cycle
  // pulse because it is cleared on every edge unless a new pick occurs.
  // The window counter is cleared on grant. The watchdog is held cleared
  // until BUSY, so it starts from zero on entry. Both counters saturate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      busOwner    <= '0;
      pointer     <= '0;
      win_cnt     <= '0;
      wd_cnt      <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= NUM_MASTERS'(1) << pick;
            busOwner <= pick;
            pointer  <= (pick == PW'(NUM_MASTERS - 1)) ? '0 : pick + PW'(1);
            win_cnt  <= '0;
          end
        end
        WAIT_BEGIN: begin
          wd_cnt <= '0;
          if (!win_done) begin
            win_cnt <= win_cnt + WW'(1);
          end
        end
        BUSY: begin
          if (dataValidIn || busErrorIn) begin
            wd_cnt <= '0;
          end else if (!wd_done) begin
            wd_cnt <= wd_cnt + DW'(1);
          end
        end
        ABORT: begin
          timeoutFlag <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register only, so no input
  // reaches an output combinationally.
  always_comb begin
    busActive         = (state != IDLE);
    busErrorOut       = (state == ABORT);
    endTransactionOut = (state == ABORT);
  end

endmodule
